hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It drives the decode stage's operand-forwarding selects (`forward_a` / `forward_b`) and generates per-register stall and flush controls for three cases: load-use hazards, taken branches/jumps, and APB/LSU wait states. A small FSM with a timeout counter holds the pipeline frozen while a memory-stage bus access is outstanding.

## Interface
Parameters:
- `TIMEOUT_W`, default 8: width of the wait-state counter.
- `TIMEOUT_CYC`, default 255: maximum number of frozen cycles before an access is aborted. Must be between 1 and 2^TIMEOUT_W-1.

Ports (clock and reset first):
- `i_clk` in 1: system clock, rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_rs1_addr_id`, `i_rs2_addr_id` in 5: source register indices of the instruction in ID.
- `i_rs1_used_id`, `i_rs2_used_id` in 1: the ID instruction actually reads rs1 / rs2.
- `i_rd_addr_ex`, `i_rd_addr_mem`, `i_rd_addr_wb` in 5: destination register index in EX, MEM and WB.
- `i_rd_wren_ex`, `i_rd_wren_mem`, `i_rd_wren_wb` in 1: register write enable in each stage.
- `i_is_load_ex`, `i_is_load_mem` in 1: the instruction in that stage is a load.
- `i_pc_sel_ex` in 1: branch taken or jump resolved in EX.
- `i_lsu_req_mem` in 1: the MEM instruction performs a bus access.
- `i_lsu_ready` in 1: bus access completes this cycle.
- `o_forward_a`, `o_forward_b` out 2: operand select. 0 = regfile, 1 = wb_data, 2 = alu_data_mem, 3 = alu_data.
- `o_stall_pc`, `o_stall_if_id`, `o_stall_id_ex`, `o_stall_ex_mem` out 1: hold the PC or the named pipeline register.
- `o_flush_if_id`, `o_flush_id_ex`, `o_flush_mem_wb` out 1: load a bubble into the named register.
- `o_lsu_err` out 1: one-cycle pulse indicating an access was aborted on timeout.
- `o_perf_stall`, `o_perf_flush`, `o_perf_tmo` out 32: performance counters (see Configuration).

## Operation
Forwarding is evaluated independently per operand. For each operand the first matching rule applies:
- Index is x0, or the operand is unused: select 0.
- EX matches with `wren` set and the EX instruction is not a load: select 3.
- MEM matches with `wren` set and the MEM instruction is not a load: select 2.
- WB matches with `wren` set: select 1.
- Otherwise: select 0.

Load-use hazard:
- Trigger: a used ID source matches the rd of a load in EX or MEM.
- Response: assert `stall_pc`, `stall_if_id` and `flush_id_ex`.
- A load in EX therefore costs 2 bubbles and a load in MEM costs 1. The dependent instruction then forwards from wb_data.

Taken branch or jump (`i_pc_sel_ex`=1): assert `flush_if_id` and `flush_id_ex` for exactly that cycle.

FSM states are RUN and MEM_WAIT.
- RUN to MEM_WAIT: when `i_lsu_req_mem` is 1 and `i_lsu_ready` is 0. The freeze is Mealy: it is asserted in the same cycle.
- Freeze outputs: `stall_pc`, `stall_if_id`, `stall_id_ex` and `stall_ex_mem` all 1, and `flush_mem_wb`=1.
- MEM_WAIT behaviour: the counter increments every cycle and the freeze holds while `i_lsu_ready`=0.
- MEM_WAIT to RUN on `i_lsu_ready`=1: the freeze drops in that same cycle and the counter clears.
- MEM_WAIT to RUN on timeout (counter = `TIMEOUT_CYC` and still not ready):
  - the freeze drops and the access retires;
  - `o_lsu_err` pulses in the following cycle;
  - the counter clears.

Priority when events coincide:
- Memory freeze beats branch flush. The branch stays held in EX and its flush is applied on the first unfrozen cycle.
- Branch flush beats load-use stall. The stall is suppressed because the ID instruction is discarded.
- Freeze plus load-use: only the freeze outputs are driven. The load-use condition is re-evaluated after release.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the current state. There are no register stages on these outputs.
- `o_lsu_err` is registered: it appears one cycle after the timeout cycle.
- Reset (`i_reset`=0): state is RUN, the counter is 0, `o_lsu_err` is 0 and all perf counters are 0. While reset is low, every stall, flush and forward output is forced to 0.
- Reset asserted during MEM_WAIT aborts the wait immediately and no error is reported.
- The counter never wraps: it saturates at `TIMEOUT_CYC`, which forces the exit.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `o_perf_stall` counts cycles with `o_stall_pc`=1;
  - `o_perf_flush` counts branch flush cycles;
  - `o_perf_tmo` counts timeouts.
  - All three are 32-bit, wrap at 2^32, and clear only on reset.
- `HAZARD_PERF_EN` undefined: the counters are not built and the three ports are tied to 0.

## Structure
- Package `hazard_pkg` holds:
  - enum `fwd_sel_e` (FWD_RF=0, FWD_WB=1, FWD_MEM=2, FWD_EX=3);
  - enum `hz_state_e` (RUN, MEM_WAIT).
- Sub-module `fwd_sel` contains the per-operand forwarding priority logic and is instantiated twice, once for rs1 and once for rs2.
- The FSM, counter and stall/flush logic stay in `hazard_ctrl`.

## Test plan
- ID rs1=x5. EX writes x5 (ALU op) and MEM also writes x5 → `o_forward_a`=3. Repeat with rs1=x0 → `o_forward_a`=0.
- Load to x7 in EX, ID reads x7 → 2 cycles of stall+bubble, then `o_forward_b`=1 when the load reaches WB.
- `i_pc_sel_ex`=1 while a load-use condition is active → `flush_if_id`=`flush_id_ex`=1 and `stall_pc`=0 for 1 cycle.
- `i_lsu_req_mem`=1 with ready low for 3 cycles, then high → all four stalls and `flush_mem_wb` high for 3 cycles, all low in the ready cycle, state returns to RUN.
- Ready held low with `TIMEOUT_CYC`=4 → freeze is released after the counter reaches 4, and `o_lsu_err` pulses once on the next cycle.
- Drop `i_reset` mid-MEM_WAIT → outputs go to 0 immediately and no `o_lsu_err`. With `HAZARD_PERF_EN` defined, `o_perf_stall` reads 0 after reset.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard controller: forwarding selects, FSM states and match helpers.
// Purely combinational helpers with no latency and no flow control of their own.
// Backpressure: not applicable; consumers decide how matches turn into stalls.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    // x0 is hardwired zero, so it never creates a dependency.
    function automatic logic src_hit(
        input logic       rs_used,
        input logic [4:0] rs_addr,
        input logic [4:0] rd_addr,
        input logic       cond
    );
        return rs_used && (rs_addr != 5'd0) && cond && (rs_addr == rd_addr);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding priority: youngest producer wins, loads skipped until their data is in WB.
// Latency: combinational, zero cycles.
// Backpressure: none; load-use stalls in hazard_ctrl cover the skipped load cases.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs_addr,
    input  logic       i_rs_used,
    input  logic [4:0] i_rd_addr_ex,
    input  logic       i_rd_wren_ex,
    input  logic       i_is_load_ex,
    input  logic [4:0] i_rd_addr_mem,
    input  logic       i_rd_wren_mem,
    input  logic       i_is_load_mem,
    input  logic [4:0] i_rd_addr_wb,
    input  logic       i_rd_wren_wb,
    output fwd_sel_e   o_sel
);

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    always_comb begin
        hit_ex  = src_hit(i_rs_used, i_rs_addr, i_rd_addr_ex, i_rd_wren_ex && !i_is_load_ex);
        hit_mem = src_hit(i_rs_used, i_rs_addr, i_rd_addr_mem, i_rd_wren_mem && !i_is_load_mem);
        hit_wb  = src_hit(i_rs_used, i_rs_addr, i_rd_addr_wb, i_rd_wren_wb);

        o_sel = FWD_RF;
        if (hit_ex) begin
            o_sel = FWD_EX;
        end else if (hit_mem) begin
            o_sel = FWD_MEM;
        end else if (hit_wb) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use stall, branch flush and bus wait-state freeze for the 5-stage core.
// Latency: all controls combinational; o_lsu_err registered one cycle after the timeout cycle.
// Backpressure: bus freeze holds every stage until ready or timeout. HAZARD_PERF_EN builds the perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_rs1_addr_id,
    input  logic [4:0]  i_rs2_addr_id,
    input  logic        i_rs1_used_id,
    input  logic        i_rs2_used_id,
    input  logic [4:0]  i_rd_addr_ex,
    input  logic [4:0]  i_rd_addr_mem,
    input  logic [4:0]  i_rd_addr_wb,
    input  logic        i_rd_wren_ex,
    input  logic        i_rd_wren_mem,
    input  logic        i_rd_wren_wb,
    input  logic        i_is_load_ex,
    input  logic        i_is_load_mem,
    input  logic        i_pc_sel_ex,
    input  logic        i_lsu_req_mem,
    input  logic        i_lsu_ready,
    output logic [1:0]  o_forward_a,
    output logic [1:0]  o_forward_b,
    output logic        o_stall_pc,
    output logic        o_stall_if_id,
    output logic        o_stall_id_ex,
    output logic        o_stall_ex_mem,
    output logic        o_flush_if_id,
    output logic        o_flush_id_ex,
    output logic        o_flush_mem_wb,
    output logic        o_lsu_err,
    output logic [31:0] o_perf_stall,
    output logic [31:0] o_perf_flush,
    output logic [31:0] o_perf_tmo
);

    localparam logic [TIMEOUT_W-1:0] TMO_LIM = TIMEOUT_W'(TIMEOUT_CYC);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);

    fwd_sel_e              fwd_a;
    fwd_sel_e              fwd_b;
    hz_state_e             state_q, state_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic                  lsu_err_q, lsu_err_d;
    logic                  freeze;
    logic                  tmo;
    logic                  load_use;
    logic                  br_flush;
    logic                  lu_stall;

    fwd_sel u_fwd_a (
        .i_rs_addr     (i_rs1_addr_id),
        .i_rs_used     (i_rs1_used_id),
        .i_rd_addr_ex  (i_rd_addr_ex),
        .i_rd_wren_ex  (i_rd_wren_ex),
        .i_is_load_ex  (i_is_load_ex),
        .i_rd_addr_mem (i_rd_addr_mem),
        .i_rd_wren_mem (i_rd_wren_mem),
        .i_is_load_mem (i_is_load_mem),
        .i_rd_addr_wb  (i_rd_addr_wb),
        .i_rd_wren_wb  (i_rd_wren_wb),
        .o_sel         (fwd_a)
    );

    fwd_sel u_fwd_b (
        .i_rs_addr     (i_rs2_addr_id),
        .i_rs_used     (i_rs2_used_id),
        .i_rd_addr_ex  (i_rd_addr_ex),
        .i_rd_wren_ex  (i_rd_wren_ex),
        .i_is_load_ex  (i_is_load_ex),
        .i_rd_addr_mem (i_rd_addr_mem),
        .i_rd_wren_mem (i_rd_wren_mem),
        .i_is_load_mem (i_is_load_mem),
        .i_rd_addr_wb  (i_rd_addr_wb),
        .i_rd_wren_wb  (i_rd_wren_wb),
        .o_sel         (fwd_b)
    );

    // Counter tracks frozen cycles, so the entry cycle already counts as one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        freeze    = 1'b0;
        tmo       = 1'b0;
        case (state_q)
            RUN: begin
                if (i_lsu_req_mem && !i_lsu_ready) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            MEM_WAIT: begin
                if (i_lsu_ready) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LIM) begin
                    tmo     = 1'b1;
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    freeze  = 1'b1;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        lsu_err_d = tmo;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            lsu_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lsu_err_q <= lsu_err_d;
        end
    end

    // Freeze outranks the branch, which outranks load-use; reset forces every control low.
    always_comb begin
        load_use = src_hit(i_rs1_used_id, i_rs1_addr_id, i_rd_addr_ex,  i_is_load_ex)
                 | src_hit(i_rs1_used_id, i_rs1_addr_id, i_rd_addr_mem, i_is_load_mem)
                 | src_hit(i_rs2_used_id, i_rs2_addr_id, i_rd_addr_ex,  i_is_load_ex)
                 | src_hit(i_rs2_used_id, i_rs2_addr_id, i_rd_addr_mem, i_is_load_mem);
        br_flush = i_reset && i_pc_sel_ex && !freeze;
        lu_stall = i_reset && load_use && !i_pc_sel_ex && !freeze;

        o_forward_a    = i_reset ? 2'(fwd_a) : 2'(FWD_RF);
        o_forward_b    = i_reset ? 2'(fwd_b) : 2'(FWD_RF);
        o_stall_pc     = (i_reset && freeze) || lu_stall;
        o_stall_if_id  = (i_reset && freeze) || lu_stall;
        o_stall_id_ex  = i_reset && freeze;
        o_stall_ex_mem = i_reset && freeze;
        o_flush_if_id  = br_flush;
        o_flush_id_ex  = br_flush || lu_stall;
        o_flush_mem_wb = i_reset && freeze;
        o_lsu_err      = lsu_err_q;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_tmo_q,   perf_tmo_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, o_stall_pc};
        perf_flush_d = perf_flush_q + {31'd0, br_flush};
        perf_tmo_d   = perf_tmo_q   + {31'd0, tmo};
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_tmo_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_tmo_q   <= perf_tmo_d;
        end
    end

    assign o_perf_stall = perf_stall_q;
    assign o_perf_flush = perf_flush_q;
    assign o_perf_tmo   = perf_tmo_q;
`else
    assign o_perf_stall = 32'd0;
    assign o_perf_flush = 32'd0;
    assign o_perf_tmo   = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT_CYC=4; expected control vectors queued per step.
module tb_hazard_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [4:0]  i_rs1_addr_id, i_rs2_addr_id;
    logic        i_rs1_used_id, i_rs2_used_id;
    logic [4:0]  i_rd_addr_ex, i_rd_addr_mem, i_rd_addr_wb;
    logic        i_rd_wren_ex, i_rd_wren_mem, i_rd_wren_wb;
    logic        i_is_load_ex, i_is_load_mem;
    logic        i_pc_sel_ex, i_lsu_req_mem, i_lsu_ready;
    logic [1:0]  o_forward_a, o_forward_b;
    logic        o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem;
    logic        o_flush_if_id, o_flush_id_ex, o_flush_mem_wb;
    logic        o_lsu_err;
    logic [31:0] o_perf_stall, o_perf_flush, o_perf_tmo;

    int n_assert = 0;
    int n_fail   = 0;

    string      tag_q[$];
    logic [11:0] exp_q[$];
    logic [11:0] obs;

    assign obs = {o_forward_a, o_forward_b,
                  o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem,
                  o_flush_if_id, o_flush_id_ex, o_flush_mem_wb, o_lsu_err};

    always #5 i_clk = ~i_clk;

    hazard_ctrl #(.TIMEOUT_W(8), .TIMEOUT_CYC(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rs1_addr_id(i_rs1_addr_id), .i_rs2_addr_id(i_rs2_addr_id),
        .i_rs1_used_id(i_rs1_used_id), .i_rs2_used_id(i_rs2_used_id),
        .i_rd_addr_ex(i_rd_addr_ex), .i_rd_addr_mem(i_rd_addr_mem), .i_rd_addr_wb(i_rd_addr_wb),
        .i_rd_wren_ex(i_rd_wren_ex), .i_rd_wren_mem(i_rd_wren_mem), .i_rd_wren_wb(i_rd_wren_wb),
        .i_is_load_ex(i_is_load_ex), .i_is_load_mem(i_is_load_mem),
        .i_pc_sel_ex(i_pc_sel_ex), .i_lsu_req_mem(i_lsu_req_mem), .i_lsu_ready(i_lsu_ready),
        .o_forward_a(o_forward_a), .o_forward_b(o_forward_b),
        .o_stall_pc(o_stall_pc), .o_stall_if_id(o_stall_if_id),
        .o_stall_id_ex(o_stall_id_ex), .o_stall_ex_mem(o_stall_ex_mem),
        .o_flush_if_id(o_flush_if_id), .o_flush_id_ex(o_flush_id_ex), .o_flush_mem_wb(o_flush_mem_wb),
        .o_lsu_err(o_lsu_err),
        .o_perf_stall(o_perf_stall), .o_perf_flush(o_perf_flush), .o_perf_tmo(o_perf_tmo)
    );

    task automatic idle();
        i_rs1_addr_id = 5'd0; i_rs2_addr_id = 5'd0; i_rs1_used_id = 1'b0; i_rs2_used_id = 1'b0;
        i_rd_addr_ex = 5'd0; i_rd_addr_mem = 5'd0; i_rd_addr_wb = 5'd0;
        i_rd_wren_ex = 1'b0; i_rd_wren_mem = 1'b0; i_rd_wren_wb = 1'b0;
        i_is_load_ex = 1'b0; i_is_load_mem = 1'b0;
        i_pc_sel_ex = 1'b0; i_lsu_req_mem = 1'b0; i_lsu_ready = 1'b0;
    endtask

    // st = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem}; fl = {flush_if_id, flush_id_ex, flush_mem_wb}
    task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [3:0] st, input logic [2:0] fl, input logic err);
        logic [11:0] e;
        string       t;
        tag_q.push_back(tag);
        exp_q.push_back({fa, fb, st, fl, err});
        @(negedge i_clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", t, obs, e);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, o, e);
        end
    endtask

    initial begin
        i_reset = 1'b0;
        idle();
        // Reset with live hazards on the inputs: everything forced low
        i_rs1_addr_id = 5'd5; i_rs1_used_id = 1'b1; i_rd_addr_ex = 5'd5; i_rd_wren_ex = 1'b1;
        i_pc_sel_ex = 1'b1; i_lsu_req_mem = 1'b1;
        step("reset_forced", 2'd0, 2'd0, 4'b0000, 3'b000, 1'b0);
        check32("reset_perf_stall", o_perf_stall, 32'd0);
        check32("reset_perf_flush", o_perf_flush, 32'd0);
        check32("reset_perf_tmo", o_perf_tmo, 32'd0);

        i_reset = 1'b1; idle();
        step("idle", 2'd0, 2'd0, 4'b0000, 3'b000, 1'b0);

        // Forwarding priority
        i_rs1_addr_id = 5'd5; i_rs1_used_id = 1'b1;
        i_rd_addr_ex = 5'd5; i_rd_wren_ex = 1'b1; i_rd_addr_mem = 5'd5; i_rd_wren_mem = 1'b1;
        step("fwd_ex_over_mem", 2'd3, 2'd0, 4'b0000, 3'b000, 1'b0);
        i_rs1_addr_id = 5'd0;
        step("fwd_x0", 2'd0, 2'd0, 4'b0000, 3'b000, 1'b0);
        i_rs1_addr_id = 5'd5; i_rd_wren_ex = 1'b0;
        step("fwd_mem", 2'd2, 2'd0, 4'b0000, 3'b000, 1'b0);
        i_rd_wren_ex = 1'b1; i_is_load_ex = 1'b1; i_is_load_mem = 1'b1;
        i_rd_addr_wb = 5'd5; i_rd_wren_wb = 1'b1;
        step("fwd_skip_loads_wb", 2'd1, 2'd0, 4'b1100, 3'b010, 1'b0);
        idle();
        i_rs1_addr_id = 5'd9; i_rs1_used_id = 1'b0; i_rd_addr_ex = 5'd9; i_rd_wren_ex = 1'b1;
        i_rs2_addr_id = 5'd9; i_rs2_used_id = 1'b1; i_is_load_ex = 1'b0;
        step("fwd_unused_a_ex_b", 2'd0, 2'd3, 4'b0000, 3'b000, 1'b0);

        // Load to x7 followed by a reader of x7
        idle();
        i_rs2_addr_id = 5'd7; i_rs2_used_id = 1'b1;
        i_rd_addr_ex = 5'd7; i_rd_wren_ex = 1'b1; i_is_load_ex = 1'b1;
        step("lu_load_ex", 2'd0, 2'd0, 4'b1100, 3'b010, 1'b0);
        i_rd_addr_ex = 5'd0; i_rd_wren_ex = 1'b0; i_is_load_ex = 1'b0;
        i_rd_addr_mem = 5'd7; i_rd_wren_mem = 1'b1; i_is_load_mem = 1'b1;
        step("lu_load_mem", 2'd0, 2'd0, 4'b1100, 3'b010, 1'b0);
        i_rd_addr_mem = 5'd0; i_rd_wren_mem = 1'b0; i_is_load_mem = 1'b0;
        i_rd_addr_wb = 5'd7; i_rd_wren_wb = 1'b1;
        step("lu_load_wb_fwd", 2'd0, 2'd1, 4'b0000, 3'b000, 1'b0);

        // Branch beats load-use
        idle();
        i_rs2_addr_id = 5'd7; i_rs2_used_id = 1'b1;
        i_rd_addr_ex = 5'd7; i_rd_wren_ex = 1'b1; i_is_load_ex = 1'b1; i_pc_sel_ex = 1'b1;
        step("branch_over_lu", 2'd0, 2'd0, 4'b0000, 3'b110, 1'b0);

        // Three wait states with a branch held in EX, then ready
        idle();
        i_lsu_req_mem = 1'b1; i_pc_sel_ex = 1'b1;
        step("wait_c1", 2'd0, 2'd0, 4'b1111, 3'b001, 1'b0);
        i_rs1_addr_id = 5'd5; i_rs1_used_id = 1'b1;
        i_rd_addr_ex = 5'd5; i_rd_wren_ex = 1'b1; i_is_load_ex = 1'b1;
        step("wait_c2_lu", 2'd0, 2'd0, 4'b1111, 3'b001, 1'b0);
        i_rs1_used_id = 1'b0; i_is_load_ex = 1'b0; i_rd_wren_ex = 1'b0;
        step("wait_c3", 2'd0, 2'd0, 4'b1111, 3'b001, 1'b0);
        i_lsu_ready = 1'b1;
        step("wait_ready_branch", 2'd0, 2'd0, 4'b0000, 3'b110, 1'b0);
        idle();
        step("wait_back_run", 2'd0, 2'd0, 4'b0000, 3'b000, 1'b0);

        // Timeout after 4 frozen cycles
        i_lsu_req_mem = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("tmo_frozen", 2'd0, 2'd0, 4'b1111, 3'b001, 1'b0);
        end
        step("tmo_release", 2'd0, 2'd0, 4'b0000, 3'b000, 1'b0);
        idle();
        step("tmo_err_pulse", 2'd0, 2'd0, 4'b0000, 3'b000, 1'b1);
        step("tmo_err_single", 2'd0, 2'd0, 4'b0000, 3'b000, 1'b0);
`ifdef HAZARD_PERF_EN
        check32("perf_flush", o_perf_flush, 32'd2);
        check32("perf_tmo", o_perf_tmo, 32'd1);
`else
        check32("perf_flush_tied", o_perf_flush, 32'd0);
        check32("perf_tmo_tied", o_perf_tmo, 32'd0);
`endif

        // Reset asserted mid-wait
        i_lsu_req_mem = 1'b1;
        step("rst_wait_c1", 2'd0, 2'd0, 4'b1111, 3'b001, 1'b0);
        step("rst_wait_c2", 2'd0, 2'd0, 4'b1111, 3'b001, 1'b0);
        step("rst_wait_c3", 2'd0, 2'd0, 4'b1111, 3'b001, 1'b0);
        i_reset = 1'b0;
        step("rst_mid_wait", 2'd0, 2'd0, 4'b0000, 3'b000, 1'b0);
        step("rst_mid_wait_hold", 2'd0, 2'd0, 4'b0000, 3'b000, 1'b0);
        check32("rst_perf_stall", o_perf_stall, 32'd0);
        i_reset = 1'b1; idle();
        step("rst_release_run", 2'd0, 2'd0, 4'b0000, 3'b000, 1'b0);
        step("rst_no_err", 2'd0, 2'd0, 4'b0000, 3'b000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
